// File: rtl/mux_rr_sel.sv
// Registered N:1 channel selector with valid/ready on every input and on the output.
// Channel is chosen by sel (mode 0) or by a rotating-priority round-robin scan (mode 1).
module mux_rr_sel #(
    parameter int W  = 3,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic          xfer;

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = grant_vld && load_en && !rst;

    // Grant decision: fixed select or first valid channel at/after ptr, wrapping.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == SW'(k) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(k);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_vld && in_valid[idx[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SW'(k)) begin
                grant_data = in_data[k*W +: W];
            end
        end
    end

    assign in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage; reset drops any held word without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
